// File: rtl/if_id_buf_if.sv
// Fetch-to-decode handshake bundle for the IF/ID stage register.
// master = fetch/decode side, slave = the if_id_buf itself.
interface if_id_buf_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned INST_W = 32
);
    logic              if_valid;
    logic [ADDR_W-1:0] if_pc;
    logic [INST_W-1:0] if_inst;
    logic              if_ready;
    logic              stall;
    logic              flush;
    logic              id_valid;
    logic [ADDR_W-1:0] id_pc;
    logic [INST_W-1:0] id_inst;

    modport master (
        output if_valid, if_pc, if_inst, stall, flush,
        input  if_ready, id_valid, id_pc, id_inst
    );

    modport slave (
        input  if_valid, if_pc, if_inst, stall, flush,
        output if_ready, id_valid, id_pc, id_inst
    );
endinterface

// File: rtl/if_id_buf.sv
// IF/ID stage register with valid/ready toward fetch, stall hold, flush/bubble insertion
// and a DEPTH-entry in-order skid buffer that catches fetch returns while decode stalls.
module if_id_buf #(
    parameter int unsigned        ADDR_W   = 32,
    parameter int unsigned        INST_W   = 32,
    parameter int unsigned        DEPTH    = 2,
    parameter logic [INST_W-1:0]  NOP_INST = '0,
    localparam int unsigned       PTR_W    = $clog2(DEPTH),
    localparam int unsigned       CNT_W    = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    if_id_buf_if.slave       bus,
    output logic [CNT_W-1:0] buf_count,
    output logic [15:0]      stall_cnt
);

    localparam logic [CNT_W-1:0] DepthCnt = CNT_W'(DEPTH);

    logic              id_valid_q, id_valid_d;
    logic [ADDR_W-1:0] id_pc_q, id_pc_d;
    logic [INST_W-1:0] id_inst_q, id_inst_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [15:0]       stall_cnt_q, stall_cnt_d;
    logic [ADDR_W-1:0] buf_pc_q [DEPTH];
    logic [ADDR_W-1:0] buf_pc_d [DEPTH];
    logic [INST_W-1:0] buf_inst_q [DEPTH];
    logic [INST_W-1:0] buf_inst_d [DEPTH];

    logic ready;
    logic accept;
    logic push;
    logic pop;

    // Ready is a pure function of registered occupancy, so no stall/flush path reaches fetch.
    assign ready  = (count_q < DepthCnt);
    assign accept = bus.if_valid && ready;

    always_comb begin
        id_valid_d  = id_valid_q;
        id_pc_d     = id_pc_q;
        id_inst_d   = id_inst_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        stall_cnt_d = stall_cnt_q;
        buf_pc_d    = buf_pc_q;
        buf_inst_d  = buf_inst_q;
        push        = 1'b0;
        pop         = 1'b0;

        if (bus.flush) begin
            id_valid_d = 1'b0;
            id_pc_d    = '0;
            id_inst_d  = NOP_INST;
        end else if (bus.stall) begin
            push = accept;
        end else if (count_q != '0) begin
            id_valid_d = 1'b1;
            id_pc_d    = buf_pc_q[rd_ptr_q];
            id_inst_d  = buf_inst_q[rd_ptr_q];
            pop        = 1'b1;
            push       = accept;
        end else if (accept) begin
            id_valid_d = 1'b1;
            id_pc_d    = bus.if_pc;
            id_inst_d  = bus.if_inst;
        end else begin
            id_valid_d = 1'b0;
            id_pc_d    = '0;
            id_inst_d  = NOP_INST;
        end

        if (push) begin
            buf_pc_d[wr_ptr_q]   = bus.if_pc;
            buf_inst_d[wr_ptr_q] = bus.if_inst;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        // Flush empties the buffer and realigns both pointers; the offered input is dropped.
        if (bus.flush) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end

        if (bus.stall && id_valid_q && !bus.flush && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_valid_q  <= 1'b0;
            id_pc_q     <= '0;
            id_inst_q   <= NOP_INST;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            stall_cnt_q <= '0;
            buf_pc_q    <= '{default: '0};
            buf_inst_q  <= '{default: '0};
        end else begin
            id_valid_q  <= id_valid_d;
            id_pc_q     <= id_pc_d;
            id_inst_q   <= id_inst_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            stall_cnt_q <= stall_cnt_d;
            buf_pc_q    <= buf_pc_d;
            buf_inst_q  <= buf_inst_d;
        end
    end

    assign bus.if_ready = ready;
    assign bus.id_valid = id_valid_q;
    assign bus.id_pc    = id_pc_q;
    assign bus.id_inst  = id_inst_q;
    assign buf_count    = count_q;
    assign stall_cnt    = stall_cnt_q;

endmodule
